cpu_run_controller: RTL and testbench

//  Host-side initiator for the processor's start/done handshake.

---
 rtl/cpu_run_controller.sv | 137 +++++++++++++
 tb/tb_cpu_run_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: host-side run sequencer for the processor.
// Loads data memory from a host stream, pulses cpu_start, waits for cpu_done
// (bounded by a RUN-cycle timeout), then streams the result window out.
module cpu_run_controller #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int LOAD_WORDS  = 64,
    parameter int DUMP_BASE   = 64,
    parameter int DUMP_WORDS  = 64,
    parameter int START_CYC   = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              go,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ready,
    output logic              cpu_start,
    input  logic              cpu_done,
    output logic              mem_own,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              dump_valid,
    output logic [DATA_W-1:0] dump_data,
    input  logic              dump_ready,
    output logic              busy,
    output logic              finished,
    output logic              timeout_err,
    output logic [15:0]       cycle_count
);

    // idx carries one extra bit so a full 2^ADDR_W load ends without wrapping
    localparam int IDX_W  = ADDR_W + 1;
    localparam int SCNT_W = (START_CYC > 1) ? $clog2(START_CYC) : 1;

    localparam logic [IDX_W-1:0]  LAST_LOAD   = IDX_W'(LOAD_WORDS - 1);
    localparam logic [IDX_W-1:0]  LAST_DUMP   = IDX_W'(DUMP_WORDS - 1);
    localparam logic [SCNT_W-1:0] LAST_START  = SCNT_W'(START_CYC - 1);
    localparam logic [15:0]       LAST_RUN    = 16'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W-1:0] DUMP_BASE_A = ADDR_W'(DUMP_BASE);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_RUN, S_DUMP, S_FIN, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       cnt_inc;

    // Next-state and counter updates
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        scnt_d  = scnt_q;
        cnt_d   = cnt_q;
        cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        case (state_q)
            S_IDLE, S_FIN, S_ERR: begin
                if (go) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (host_valid) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_LOAD) begin
                        state_d = S_START;
                        scnt_d  = '0;
                    end
                end
            end
            S_START: begin
                // cpu_done is deliberately not looked at until RUN
                if (scnt_q == LAST_START) state_d = S_RUN;
                else                      scnt_d  = scnt_q + 1'b1;
            end
            S_RUN: begin
                // done takes priority over a coincident timeout; count freezes on done
                if (cpu_done) begin
                    state_d = S_DUMP;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_q == LAST_RUN) state_d = S_ERR;
                end
            end
            S_DUMP: begin
                if (dump_ready) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_DUMP) state_d = S_FIN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and counter registers, cleared asynchronously
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            scnt_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            scnt_q  <= scnt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode the registered state so reset clears them at once
    always_comb begin
        host_ready  = (state_q == S_LOAD);
        cpu_start   = (state_q == S_START);
        dump_valid  = (state_q == S_DUMP);
        mem_own     = host_ready | dump_valid;
        mem_we      = host_ready & host_valid;
        mem_addr    = '0;
        if (host_ready) mem_addr = idx_q[ADDR_W-1:0];
        if (dump_valid) mem_addr = DUMP_BASE_A + idx_q[ADDR_W-1:0];
        mem_wdata   = host_ready ? host_data : '0;
        dump_data   = dump_valid ? mem_rdata : '0;
        busy        = !(state_q inside {S_IDLE, S_FIN, S_ERR});
        finished    = (state_q == S_FIN);
        timeout_err = (state_q == S_ERR);
        cycle_count = cnt_q;
    end

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb_cpu_run_controller: randomized runs of the controller against a bench
// memory and a simple processor model that writes word i of the result window
// as (loaded word i) ^ key. Expected writes and dump words go into queues that
// independent monitors pop and compare.
module tb_cpu_run_controller;

    localparam int TO = 128;   // short timeout so ERR and the done-at-limit case are reachable

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       go = 1'b0, host_valid = 1'b0, cpu_done = 1'b0, dump_ready = 1'b0;
    logic [7:0] host_data = 8'h0;
    logic       host_ready, cpu_start, mem_own, mem_we, dump_valid;
    logic       busy, finished, timeout_err;
    logic [7:0] mem_addr, mem_wdata, mem_rdata, dump_data;
    logic [15:0] cycle_count;

    // processor-side memory port, used only while the controller does not own memory
    logic       cpu_we = 1'b0;
    logic [7:0] cpu_addr = 8'h0, cpu_wdata = 8'h0;
    logic [7:0] mem [0:255];

    int chk = 0, err = 0;
    logic [15:0] wq[$];      // expected {addr,data} for each controller write
    logic [7:0]  exp_q[$];   // expected dump words in order
    logic        stalled = 1'b0;
    logic [7:0]  held = 8'h0;

    cpu_run_controller #(.ADDR_W(8), .DATA_W(8), .LOAD_WORDS(64), .DUMP_BASE(64),
                         .DUMP_WORDS(64), .START_CYC(2), .TIMEOUT_CYC(TO)) dut (
        .clock(clk), .reset(rst), .go(go), .host_valid(host_valid), .host_data(host_data),
        .host_ready(host_ready), .cpu_start(cpu_start), .cpu_done(cpu_done),
        .mem_own(mem_own), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dump_valid(dump_valid), .dump_data(dump_data),
        .dump_ready(dump_ready), .busy(busy), .finished(finished),
        .timeout_err(timeout_err), .cycle_count(cycle_count));

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_own && mem_we) mem[mem_addr] <= mem_wdata;
        else if (cpu_we)       mem[cpu_addr] <= cpu_wdata;
    end

    task automatic check(input string nm, input longint act, input longint exp);
        chk++;
        if (act != exp) begin
            err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // write monitor: every controller write must match the next expected one
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            check("we_with_own", mem_own, 1);
            check("we_not_dump", dump_valid, 0);
            if (wq.size() == 0) check("unexpected_write", {mem_addr, mem_wdata}, -1);
            else                check("mem_write", {mem_addr, mem_wdata}, wq.pop_front());
        end
    end

    // dump monitor: stable data under backpressure, in-order words on accept
    always @(negedge clk) begin
        if (!rst) begin
            if (stalled) begin
                check("dump_valid_held", dump_valid, 1);
                if (dump_valid) check("dump_data_stable", dump_data, held);
            end
            if (dump_valid && dump_ready) begin
                if (exp_q.size() == 0) check("unexpected_dump", dump_data, -1);
                else                   check("dump_word", dump_data, exp_q.pop_front());
            end
            stalled = dump_valid && !dump_ready;
            held    = dump_data;
        end else begin
            stalled = 1'b0;
        end
    end

    // Load 64 random words, optionally with gaps and stray go pulses.
    task automatic load(input logic [7:0] w[64], input bit bp);
        int i = 0, n = 0;
        bit acc;
        while (i < 64 && n < 1000) begin
            if (bp && $urandom_range(0, 1) == 0) host_valid = 1'b0;
            else begin
                host_valid = 1'b1;
                host_data  = w[i];
                wq.push_back({8'(i), w[i]});
            end
            go  = bp && ($urandom_range(0, 5) == 0);
            acc = host_valid && host_ready;
            tick;
            if (acc) i++;
            n++;
        end
        host_valid = 1'b0;
        go = 1'b0;
        check("load_complete", i, 64);
    endtask

    // One full run. early: done raised during START; to: done never raised.
    task automatic run(input int delay, input bit bp, input bit early, input bit to);
        logic [7:0] w[64];
        logic [7:0] key;
        int n;
        key = 8'($urandom);
        foreach (w[i]) w[i] = 8'($urandom);
        if (early) begin
            for (int i = 0; i < 64; i++) begin
                cpu_we = 1'b1; cpu_addr = 8'(64 + i); cpu_wdata = w[i] ^ key;
                tick;
            end
            cpu_we = 1'b0;
        end
        if (!to) foreach (w[i]) exp_q.push_back(w[i] ^ key);
        go = 1'b1;
        tick;
        go = 1'b0;
        check("busy_after_go", busy, 1);
        check("flags_clear_on_go", {finished, timeout_err}, 0);
        check("count_clear_on_go", cycle_count, 0);
        load(w, bp);
        if (early) cpu_done = 1'b1;
        n = 0;
        while (cpu_start && n < 20) begin
            n++;
            tick;
        end
        check("start_len", n, 2);
        if (!early) begin
            for (int i = 0; i < 64; i++) begin
                if (i == 0) check("run_mem_released", mem_own, 0);
                cpu_we = 1'b1; cpu_addr = 8'(64 + i); cpu_wdata = mem[i] ^ key;
                tick;
            end
            cpu_we = 1'b0;
            if (!to) begin
                repeat (delay - 64) tick;
                cpu_done = 1'b1;
            end
        end
        n = 0;
        while (busy && n < 5000) begin
            dump_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            go = bp && ($urandom_range(0, 7) == 0);
            tick;
            n++;
        end
        go = 1'b0;
        dump_ready = 1'b0;
        cpu_done = 1'b0;
        check("run_ended", busy, 0);
        if (to) begin
            check("timeout_err", timeout_err, 1);
            check("timeout_finished", finished, 0);
            check("timeout_count", cycle_count, TO);
            check("timeout_cycles", n + 64, TO);
        end else begin
            check("finished", finished, 1);
            check("no_timeout", timeout_err, 0);
            check("cycle_count", cycle_count, early ? 0 : delay);
            check("all_dumped", exp_q.size(), 0);
        end
        check("all_written", wq.size(), 0);
    endtask

    task automatic reset_mid_run;
        logic [7:0] w[64];
        foreach (w[i]) w[i] = 8'($urandom);
        go = 1'b1;
        tick;
        go = 1'b0;
        load(w, 1'b0);
        repeat (2 + 5) tick;               // 2 START cycles, then 5 RUN cycles
        check("mid_run_count", cycle_count, 5);
        check("mid_run_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("rst_cpu_start", cpu_start, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_own", mem_own, 0);
        check("rst_count", cycle_count, 0);
        check("rst_flags", {mem_we, dump_valid, finished, timeout_err}, 0);
        tick;
        rst = 1'b0;
        tick;
    endtask

    initial begin
        #2;
        check("reset_outputs", {host_ready, cpu_start, mem_own, mem_we, mem_addr, mem_wdata,
                                dump_valid, dump_data, busy, finished, timeout_err, cycle_count}, 0);
        tick;
        rst = 1'b0;
        tick;
        check("idle_not_busy", busy, 0);
        run(100, 1'b0, 1'b0, 1'b0);        // basic run
        run(90, 1'b1, 1'b0, 1'b0);         // backpressure on both streams
        run(0, 1'b0, 1'b0, 1'b1);          // timeout
        run(TO - 1, 1'b1, 1'b0, 1'b0);     // done on last RUN cycle wins; go clears ERR
        run(0, 1'b0, 1'b1, 1'b0);          // done already high in START
        reset_mid_run;
        run(64 + $urandom_range(0, 60), 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) run(64 + $urandom_range(0, 60), 1'b1, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", chk, err);
        $fatal(1, "watchdog");
    end

endmodule
